master_port: RTL
================

MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the address width in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width in bits.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent waiting for a slave response.
REQ-004 clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 start  in  1  SHALL be a one-cycle transaction request from the local controller.
REQ-007 mode  in  1  SHALL select the transaction type: 1 = write, 0 = read; sampled with start.
REQ-008 addr  in  ADDR_W  SHALL be the target address; sampled with start.
REQ-009 wdata  in  DATA_W  SHALL be the write data; sampled with start.
REQ-010 rdata  out  DATA_W  SHALL carry the assembled read data.
REQ-011 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-012 done  out  1  SHALL be a one-cycle pulse marking transaction end.
REQ-013 err  out  1  SHALL be a status flag, valid while done is high: 1 = aborted or timed out.
REQ-014 bus_req  out  1  SHALL be the request line to the bus arbiter.
REQ-015 bus_grant  in  1  SHALL be the grant line from the bus arbiter (registered there).
REQ-016 m_dout  out  1  SHALL be the serial address/write-data bit, LSB first.
REQ-017 m_valid  out  1  SHALL qualify m_dout.
REQ-018 m_mode  out  1  SHALL be the latched mode, driven for the whole transfer.
REQ-019 s_din  in  1  SHALL be the serial read-data bit from the slave, LSB first.
REQ-020 s_valid  in  1  SHALL qualify s_din.
REQ-021 s_ack  in  1  SHALL be the slave write-complete acknowledge.

Function
REQ-022 States SHALL be IDLE, REQ, ADDR, WDATA, WACK, RWAIT, DONE.
REQ-023 IDLE: a start sampled high SHALL latch mode, addr and wdata and move to REQ; start sampled in any other state SHALL be ignored.
REQ-024 bus_req SHALL be high in REQ, ADDR, WDATA, WACK and RWAIT, and low in IDLE and DONE.
REQ-025 REQ: a bus_grant sampled high SHALL move to ADDR with the bit counter cleared; the block SHALL wait in REQ indefinitely with no timeout.
REQ-026 ADDR: SHALL drive m_valid=1 and m_dout=addr[cnt] for exactly ADDR_W cycles (cnt 0..ADDR_W-1); after the last bit SHALL move to WDATA if write, RWAIT if read.
REQ-027 WDATA: SHALL drive m_valid=1 and m_dout=wdata[cnt] for exactly DATA_W cycles, then move to WACK.
REQ-028 m_valid SHALL be 0 in every state other than ADDR and WDATA; m_dout SHALL be 0 whenever m_valid=0.
REQ-029 WACK: an s_ack sampled high SHALL move to DONE with err=0.
REQ-030 RWAIT: each cycle with s_valid=1 SHALL shift s_din into rdata bit position cnt; after DATA_W valid bits SHALL move to DONE with err=0; cycles with s_valid=0 SHALL be gaps that do not advance cnt.
REQ-031 Timeout: a wait counter SHALL clear on entry to WACK or RWAIT and on each accepted s_valid bit; when it reaches TIMEOUT, the block SHALL move to DONE with err=1.
REQ-032 Grant loss: bus_grant sampled low in ADDR, WDATA, WACK or RWAIT SHALL move to DONE with err=1 on that edge; any partial rdata SHALL be retained.
REQ-033 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE; err SHALL hold its value until the next transaction leaves IDLE.
REQ-034 A start in the IDLE cycle immediately following DONE SHALL be accepted.
REQ-035 Latency: with bus_grant already high in REQ, the first address bit SHALL appear 2 cycles after start is sampled; a write with an immediate s_ack SHALL complete in 2+ADDR_W+DATA_W+2 cycles from start to done.

Reset
REQ-036 rst_n low at a clock edge SHALL force state to IDLE and set rdata=0, busy=0, done=0, err=0, bus_req=0, m_dout=0, m_valid=0, m_mode=0, with all counters cleared; this applies mid-transaction with no done pulse.

Verification
REQ-037 Write, addr=0xA5C, wdata=0x3B, grant high one cycle after bus_req, s_ack after 3 cycles -> m_dout sequence 0,0,1,1,1,0,1,0,0,1,0,1 then 1,1,0,1,1,1,0,0; done with err=0.
REQ-038 Read, addr=0x001, slave returns 0xC6 with two s_valid gaps -> rdata=0xC6, done, err=0, exactly 8 bits accepted.
REQ-039 start asserted again during ADDR with different addr -> ignored; the original addr shifts out unchanged; a single done pulse.
REQ-040 bus_grant dropped at ADDR bit 5 -> m_valid=0 on the next cycle; done with err=1; bus_req low in DONE.
REQ-041 Write with s_ack never asserted -> done with err=1 exactly TIMEOUT cycles after WACK entry.
REQ-042 rst_n low during RWAIT after 4 bits received -> all outputs at reset values, no done pulse; a subsequent transaction completes normally.

Source files
------------

// File: rtl/master_port.sv
// master_port: local-controller side of a bit-serial bus master.
// A transaction is requested with a one-cycle start pulse. The block then asks the
// arbiter for the bus and shifts the address out LSB first. For a write it then
// shifts the write data out and waits for the slave acknowledge. For a read it
// collects DATA_W qualified serial bits from the slave.
// Waiting for a slave response is bounded by TIMEOUT cycles. Losing the grant
// mid-transfer aborts the transaction. Either case ends in DONE with err set.
// All outputs are decoded from registered state, so none of them has a
// combinational path from an input.

module master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              m_dout,
  output logic              m_valid,
  output logic              m_mode,
  input  logic              s_din,
  input  logic              s_valid,
  input  logic              s_ack
);

  // The bit counter is shared by the address, write-data and read-data phases,
  // so it is sized for the wider of the two fields.
  localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WDATA,
    WACK,
    RWAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: sequencing, bit/wait counting, read-data capture and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          wait_d  = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (bus_grant) begin
          cnt_d   = '0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          wait_d  = '0;
          state_d = mode_q ? WDATA : RWAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WDATA: begin
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          wait_d  = '0;
          state_d = WACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WACK: begin
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (s_ack) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RWAIT: begin
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (s_valid) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              rdata_d[i] = s_din;
            end
          end
          wait_d = '0;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: bus request, serial output mux and status, all from registered state.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    bus_req = (state_q == REQ) || (state_q == ADDR) || (state_q == WDATA) ||
              (state_q == WACK) || (state_q == RWAIT);
    m_valid = 1'b0;
    m_dout  = 1'b0;
    case (state_q)
      ADDR: begin
        m_valid = 1'b1;
        for (int i = 0; i < ADDR_W; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            m_dout = addr_q[i];
          end
        end
      end
      WDATA: begin
        m_valid = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            m_dout = wdata_q[i];
          end
        end
      end
      default: begin
        m_valid = 1'b0;
        m_dout  = 1'b0;
      end
    endcase
  end

  assign rdata  = rdata_q;
  assign err    = err_q;
  assign m_mode = mode_q;

endmodule
